dm_hart_ctrl: RTL

Debug-module-side controller for a single hart. It is the initiator end of the core's halt/resume and abstract-register-access interface. It decodes DMI register accesses (dmcontrol, dmstatus, abstractcs, command, data0), drives haltreq/resumereq and tracks the core's running/halted/resumeack status. It also sequences Access Register abstract commands onto the core's dbg_ar_* port. It sits between the DMI/DTM front end and the core debug FSM.

---
 rtl/dm_hart_ctrl_if.sv | 21 ++
 rtl/dm_hart_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dm_hart_ctrl_if.sv
// DMI request/response bundle between the DTM front end (master) and the debug module (slave).
interface dm_hart_ctrl_if #(
  parameter int unsigned ADDR_W = 7
) ();
  logic              req_valid;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic              resp_valid;
  logic [31:0]       resp_data;

  modport master (
    output req_valid, req_wr, req_addr, req_data,
    input  resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_data,
    output resp_valid, resp_data
  );
endinterface

// File: rtl/dm_hart_ctrl.sv
// Debug-module controller for one hart: DMI register decode, halt/resume handshake and
// Access Register abstract commands. Define DM_AUTOEXEC_EN to add abstractauto (0x18).
module dm_hart_ctrl #(
  parameter int unsigned DMI_ADDR_W  = 7,
  parameter logic [31:0] DATA0_RESET = 32'h0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  dm_hart_ctrl_if.slave dmi,
  output logic        dbg_haltreq_o,
  output logic        dbg_resumereq_o,
  input  logic        core_resumeack_i,
  input  logic        core_running_i,
  input  logic        core_halted_i,
  output logic        dbg_ar_en_o,
  output logic        dbg_ar_wr_o,
  output logic [15:0] dbg_ar_ad_o,
  output logic [31:0] dbg_ar_do_o,
  input  logic [31:0] dbg_ar_di_i
);

  localparam logic [DMI_ADDR_W-1:0] A_DATA0     = DMI_ADDR_W'(7'h04);
  localparam logic [DMI_ADDR_W-1:0] A_DMCONTROL = DMI_ADDR_W'(7'h10);
  localparam logic [DMI_ADDR_W-1:0] A_DMSTATUS  = DMI_ADDR_W'(7'h11);
  localparam logic [DMI_ADDR_W-1:0] A_ABSCS     = DMI_ADDR_W'(7'h16);
  localparam logic [DMI_ADDR_W-1:0] A_COMMAND   = DMI_ADDR_W'(7'h17);
`ifdef DM_AUTOEXEC_EN
  localparam logic [DMI_ADDR_W-1:0] A_ABSAUTO   = DMI_ADDR_W'(7'h18);
`endif

  typedef enum logic {R_IDLE, R_REQ} r_state_e;
  typedef enum logic [1:0] {C_IDLE, C_EXEC, C_READ} c_state_e;

  r_state_e    r_state;
  c_state_e    c_state;
  logic        dmactive;
  logic        haltreq;
  logic        resumeack;
  logic [2:0]  cmderr;
  logic [31:0] data0;

  logic        busy;
  logic        wr_c, rd_c, act_wr;
  logic        hit_data0, hit_dmcontrol, hit_acs, hit_command;
  logic        ctrl_wr, data0_wr, acs_wr, cmd_wr, busy_err;
  logic        cmd_trig, cmd_eval, cmd_bad, cmd_launch;
  logic [31:0] cmd_word;
  logic [31:0] ar_do_next;
  logic [31:0] rd_data;
  logic        unused_cmd_bits;

`ifdef DM_AUTOEXEC_EN
  logic        autoexecdata;
  logic [31:0] last_cmd;
  logic        hit_auto;
  logic        auto_trig;
`endif

  // Access decode; once deactivated only a dmcontrol write setting dmactive is honoured.
  always_comb begin
    busy          = (c_state != C_IDLE);
    wr_c          = dmi.req_valid & dmi.req_wr;
    rd_c          = dmi.req_valid & ~dmi.req_wr;
    act_wr        = wr_c & dmactive;
    hit_data0     = (dmi.req_addr == A_DATA0);
    hit_dmcontrol = (dmi.req_addr == A_DMCONTROL);
    hit_acs       = (dmi.req_addr == A_ABSCS);
    hit_command   = (dmi.req_addr == A_COMMAND);
    ctrl_wr       = wr_c & hit_dmcontrol & (dmactive | dmi.req_data[0]);
    data0_wr      = act_wr & hit_data0 & ~busy;
    acs_wr        = act_wr & hit_acs & ~busy;
    cmd_wr        = act_wr & hit_command & ~busy;
    busy_err      = act_wr & busy & (hit_data0 | hit_acs | hit_command);
    ar_do_next    = data0_wr ? dmi.req_data : data0;
`ifdef DM_AUTOEXEC_EN
    hit_auto      = (dmi.req_addr == A_ABSAUTO);
    auto_trig     = dmi.req_valid & dmactive & autoexecdata & ~busy & hit_data0;
    cmd_trig      = cmd_wr | auto_trig;
    cmd_word      = cmd_wr ? dmi.req_data : last_cmd;
`else
    cmd_trig      = cmd_wr;
    cmd_word      = dmi.req_data;
`endif
    cmd_eval      = cmd_trig & (cmderr == 3'd0);
    cmd_bad       = (cmd_word[31:24] != 8'd0) || (cmd_word[22:20] != 3'd2);
    cmd_launch    = cmd_eval & ~cmd_bad & core_halted_i & cmd_word[17];
  end

  assign unused_cmd_bits = ^{cmd_word[23], cmd_word[19:18]};

  // Read data mux, captured into the response register on the request edge.
  always_comb begin
    rd_data = 32'h0;
    case (dmi.req_addr)
      A_DATA0:     rd_data = data0;
      A_DMCONTROL: rd_data = {haltreq, 30'h0, dmactive};
      A_DMSTATUS:  rd_data = {14'h0, resumeack, resumeack, 4'h0,
                              core_running_i, core_running_i,
                              core_halted_i, core_halted_i, 1'b1, 3'h0, 4'd2};
      A_ABSCS:     rd_data = {19'h0, busy, 1'b0, cmderr, 4'h0, 4'd1};
`ifdef DM_AUTOEXEC_EN
      A_ABSAUTO:   rd_data = {31'h0, autoexecdata};
`endif
      default:     rd_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state         <= R_IDLE;
      c_state         <= C_IDLE;
      dmactive        <= 1'b0;
      haltreq         <= 1'b0;
      resumeack       <= 1'b0;
      cmderr          <= 3'd0;
      data0           <= DATA0_RESET;
      dmi.resp_valid  <= 1'b0;
      dmi.resp_data   <= 32'h0;
      dbg_haltreq_o   <= 1'b0;
      dbg_resumereq_o <= 1'b0;
      dbg_ar_en_o     <= 1'b0;
      dbg_ar_wr_o     <= 1'b0;
      dbg_ar_ad_o     <= 16'h0;
      dbg_ar_do_o     <= 32'h0;
`ifdef DM_AUTOEXEC_EN
      autoexecdata    <= 1'b0;
      last_cmd        <= 32'h0;
`endif
    end else begin
      dmi.resp_valid <= rd_c;
      if (rd_c) dmi.resp_data <= rd_data;
      dbg_ar_en_o <= 1'b0;

      // Resume handshake: request is held until the core reports it has resumed.
      case (r_state)
        R_IDLE: begin
          if (ctrl_wr && dmi.req_data[0] && dmi.req_data[30] && !dmi.req_data[31] && core_halted_i) begin
            r_state         <= R_REQ;
            dbg_resumereq_o <= 1'b1;
            resumeack       <= 1'b0;
          end
        end
        R_REQ: begin
          if (core_resumeack_i) begin
            r_state         <= R_IDLE;
            dbg_resumereq_o <= 1'b0;
            resumeack       <= 1'b1;
          end
        end
        default: r_state <= R_IDLE;
      endcase

      if (ctrl_wr) begin
        dmactive      <= dmi.req_data[0];
        haltreq       <= dmi.req_data[31];
        dbg_haltreq_o <= dmi.req_data[0] & dmi.req_data[31];
      end

      if (data0_wr) data0 <= dmi.req_data;
      if (acs_wr) cmderr <= cmderr & ~dmi.req_data[10:8];
      if (busy_err && cmderr == 3'd0) cmderr <= 3'd1;

`ifdef DM_AUTOEXEC_EN
      if (act_wr && hit_auto && !busy) autoexecdata <= dmi.req_data[0];
      if (cmd_wr && cmderr == 3'd0) last_cmd <= dmi.req_data;
`endif

      // Command FSM: checks on acceptance, one EXEC cycle, optional READ-back cycle.
      case (c_state)
        C_IDLE: begin
          if (cmd_eval) begin
            if (cmd_bad)             cmderr <= 3'd2;
            else if (!core_halted_i) cmderr <= 3'd4;
          end
          if (cmd_launch) begin
            c_state     <= C_EXEC;
            dbg_ar_en_o <= 1'b1;
            dbg_ar_wr_o <= cmd_word[16];
            dbg_ar_ad_o <= cmd_word[15:0];
            dbg_ar_do_o <= ar_do_next;
          end
        end
        C_EXEC:  c_state <= dbg_ar_wr_o ? C_IDLE : C_READ;
        C_READ: begin
          data0   <= dbg_ar_di_i;
          c_state <= C_IDLE;
        end
        default: c_state <= C_IDLE;
      endcase

      // Clearing dmactive returns the DM to its reset-equivalent state.
      if (ctrl_wr && !dmi.req_data[0]) begin
        haltreq         <= 1'b0;
        dbg_haltreq_o   <= 1'b0;
        r_state         <= R_IDLE;
        dbg_resumereq_o <= 1'b0;
        resumeack       <= 1'b0;
        cmderr          <= 3'd0;
        data0           <= DATA0_RESET;
        c_state         <= C_IDLE;
        dbg_ar_en_o     <= 1'b0;
`ifdef DM_AUTOEXEC_EN
        autoexecdata    <= 1'b0;
`endif
      end
    end
  end

endmodule
